// File: rtl/ds_scoreboard_pkg.sv
// Shared defaults and the counter-operation decode used by the register scoreboard.
package ds_scoreboard_pkg;

  localparam int NREG_DEF  = 32;
  localparam int AW_DEF    = 5;
  localparam int NRD_DEF   = 2;
  localparam int CNT_W_DEF = 3;

  typedef enum logic [1:0] {
    CNT_HOLD = 2'd0,
    CNT_INC  = 2'd1,
    CNT_DEC  = 2'd2,
    CNT_CLR  = 2'd3
  } cnt_op_e;

  // Clear dominates; a simultaneous inc and dec cancel out.
  function automatic cnt_op_e cnt_op(input logic clr, input logic inc, input logic dec);
    if (clr)              return CNT_CLR;
    else if (inc && !dec) return CNT_INC;
    else if (dec && !inc) return CNT_DEC;
    else                  return CNT_HOLD;
  endfunction

endpackage

// File: rtl/ds_scoreboard_counter.sv
// Up/down saturating in-flight counter; err pulses on an attempted overflow or underflow.
module sb_counter
  import ds_scoreboard_pkg::*;
#(
  parameter int W = CNT_W_DEF
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clr,
  input  logic         inc,
  input  logic         dec,
  output logic [W-1:0] cnt,
  output logic         is_zero,
  output logic         is_max,
  output logic         will_be_zero,
  output logic         err
);

  logic [W-1:0] cnt_q, cnt_d;

  assign cnt     = cnt_q;
  assign is_zero = (cnt_q == '0);
  assign is_max  = &cnt_q;
  // Ignores a same-cycle inc so queries never depend on the issue decision they gate.
  assign will_be_zero = dec && (cnt_q == W'(1));

  always_comb begin
    cnt_d = cnt_q;
    err   = 1'b0;
    unique case (cnt_op(clr, inc, dec))
      CNT_CLR: cnt_d = '0;
      CNT_INC: begin
        if (is_max) err = 1'b1;
        else        cnt_d = cnt_q + W'(1);
      end
      CNT_DEC: begin
        if (is_zero) err = 1'b1;
        else         cnt_d = cnt_q - W'(1);
      end
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

endmodule

// File: rtl/ds_scoreboard.sv
// ID-stage register scoreboard: per-register in-flight and late-write counters with source queries.
module ds_scoreboard
  import ds_scoreboard_pkg::*;
#(
  parameter int NREG          = NREG_DEF,
  parameter int AW            = AW_DEF,
  parameter int NRD           = NRD_DEF,
  parameter int CNT_W         = CNT_W_DEF,
  parameter bit BYPASS_RETIRE = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ds_issue,
  input  logic              ds_issue_we,
  input  logic [AW-1:0]     ds_issue_dest,
  input  logic              ds_issue_late,
  input  logic              ws_retire,
  input  logic [AW-1:0]     ws_retire_dest,
  input  logic              ws_retire_late,
  input  logic              flush,
  input  logic [NRD*AW-1:0] rd_addr,
  output logic [NRD-1:0]    rd_busy,
  output logic [NRD-1:0]    rd_late,
  output logic              dest_full,
  output logic              sb_err
);

  logic             issue_hit, retire_hit, inv_viol, sb_err_q, sb_err_d;
  logic [NREG-1:0]  cnt_zero, cnt_max, cnt_wbz, late_zero, late_wbz;
  logic [NREG-1:1]  cnt_err, late_err, late_max;
  logic [CNT_W-1:0] cnt_v      [1:NREG-1];
  logic [CNT_W-1:0] late_cnt_v [1:NREG-1];

  assign issue_hit  = ds_issue && ds_issue_we && (ds_issue_dest != '0);
  assign retire_hit = ws_retire && (ws_retire_dest != '0);

  // r0 is never tracked: it always reads as idle and can never be full.
  assign cnt_zero[0]  = 1'b1;
  assign cnt_max[0]   = 1'b0;
  assign cnt_wbz[0]   = 1'b0;
  assign late_zero[0] = 1'b1;
  assign late_wbz[0]  = 1'b0;

  generate
    for (genvar gi = 1; gi < NREG; gi++) begin : g_reg
      logic inc, dec;
      assign inc = issue_hit  && (ds_issue_dest  == AW'(gi));
      assign dec = retire_hit && (ws_retire_dest == AW'(gi));

      sb_counter #(.W(CNT_W)) u_cnt (
        .clk          (clk),
        .reset        (reset),
        .clr          (flush),
        .inc          (inc),
        .dec          (dec),
        .cnt          (cnt_v[gi]),
        .is_zero      (cnt_zero[gi]),
        .is_max       (cnt_max[gi]),
        .will_be_zero (cnt_wbz[gi]),
        .err          (cnt_err[gi])
      );

      sb_counter #(.W(CNT_W)) u_late (
        .clk          (clk),
        .reset        (reset),
        .clr          (flush),
        .inc          (inc && ds_issue_late),
        .dec          (dec && ws_retire_late),
        .cnt          (late_cnt_v[gi]),
        .is_zero      (late_zero[gi]),
        .is_max       (late_max[gi]),
        .will_be_zero (late_wbz[gi]),
        .err          (late_err[gi])
      );
    end

    for (genvar gi = 0; gi < NRD; gi++) begin : g_query
      logic [AW-1:0] addr;
      assign addr        = rd_addr[gi*AW +: AW];
      assign rd_busy[gi] = !cnt_zero[addr]  && !(BYPASS_RETIRE && cnt_wbz[addr]);
      assign rd_late[gi] = !late_zero[addr] && !(BYPASS_RETIRE && late_wbz[addr]);
    end
  endgenerate

  assign dest_full = cnt_max[ds_issue_dest] &&
                     !(BYPASS_RETIRE && retire_hit && (ws_retire_dest == ds_issue_dest));

  always_comb begin
    inv_viol = 1'b0;
    for (int r = 1; r < NREG; r++) begin
      if ((late_cnt_v[r] > cnt_v[r]) || (late_max[r] && !cnt_max[r])) inv_viol = 1'b1;
    end
  end

  assign sb_err_d = sb_err_q || (|cnt_err) || (|late_err) || inv_viol;
  assign sb_err   = sb_err_q;

  // Only reset clears the sticky error; flush leaves it alone.
  always_ff @(posedge clk) begin
    if (reset) sb_err_q <= 1'b0;
    else       sb_err_q <= sb_err_d;
  end

endmodule

// File: tb/tb_ds_scoreboard.sv
// Scoreboard bench for ds_scoreboard: a behavioural count model predicts outputs each cycle.
module tb_ds_scoreboard;

  logic       clk = 1'b0;
  logic       reset, ds_issue, ds_issue_we, ds_issue_late;
  logic       ws_retire, ws_retire_late, flush;
  logic [4:0] ds_issue_dest, ws_retire_dest;
  logic [9:0] rd_addr;
  logic [1:0] rd_busy, rd_late;
  logic       dest_full, sb_err;

  always #5 clk = ~clk;

  ds_scoreboard dut (
    .clk            (clk),
    .reset          (reset),
    .ds_issue       (ds_issue),
    .ds_issue_we    (ds_issue_we),
    .ds_issue_dest  (ds_issue_dest),
    .ds_issue_late  (ds_issue_late),
    .ws_retire      (ws_retire),
    .ws_retire_dest (ws_retire_dest),
    .ws_retire_late (ws_retire_late),
    .flush          (flush),
    .rd_addr        (rd_addr),
    .rd_busy        (rd_busy),
    .rd_late        (rd_late),
    .dest_full      (dest_full),
    .sb_err         (sb_err)
  );

  typedef struct {
    logic       iss, we, late;
    logic [4:0] dest;
    logic       ret, rlate;
    logic [4:0] rdest;
    logic       fl, rst;
    logic [4:0] a1, a0;
  } vec_t;

  typedef struct {
    string      tag;
    logic [5:0] val;
  } exp_t;

  exp_t exp_q[$];
  int   cnt_m[32];
  int   late_m[32];
  bit   err_m;
  int   n_vec = 0;
  int   n_miss = 0;

  function automatic vec_t mk(input logic iss, input logic we, input logic [4:0] dest,
                              input logic late, input logic ret, input logic [4:0] rdest,
                              input logic rlate, input logic fl, input logic rst,
                              input logic [4:0] a1, input logic [4:0] a0);
    vec_t v;
    v.iss = iss; v.we = we; v.dest = dest; v.late = late;
    v.ret = ret; v.rdest = rdest; v.rlate = rlate;
    v.fl = fl; v.rst = rst; v.a1 = a1; v.a0 = a0;
    return v;
  endfunction

  task automatic drive(input vec_t v);
    ds_issue = v.iss; ds_issue_we = v.we; ds_issue_dest = v.dest; ds_issue_late = v.late;
    ws_retire = v.ret; ws_retire_dest = v.rdest; ws_retire_late = v.rlate;
    flush = v.fl; reset = v.rst; rd_addr = {v.a1, v.a0};
  endtask

  // Expected {rd_busy, rd_late, dest_full, sb_err} from model state plus current inputs.
  function automatic logic [5:0] predict();
    logic [1:0] b, l;
    logic       f;
    int         d;
    for (int i = 0; i < 2; i++) begin
      int a;
      a = int'(rd_addr[i*5 +: 5]);
      b[i] = (a != 0) && (cnt_m[a] != 0) &&
             !(ws_retire && int'(ws_retire_dest) == a && cnt_m[a] == 1);
      l[i] = (a != 0) && (late_m[a] != 0) &&
             !(ws_retire && ws_retire_late && int'(ws_retire_dest) == a && late_m[a] == 1);
    end
    d = int'(ds_issue_dest);
    f = (d != 0) && (cnt_m[d] == 7) && !(ws_retire && ws_retire_dest == ds_issue_dest);
    return {b, l, f, err_m};
  endfunction

  function automatic int nxt(input int c, input bit i, input bit d);
    if (i && !d) begin
      if (c == 7) begin err_m = 1'b1; return c; end
      return c + 1;
    end
    if (d && !i) begin
      if (c == 0) begin err_m = 1'b1; return c; end
      return c - 1;
    end
    return c;
  endfunction

  task automatic update_model();
    if (reset || flush) begin
      for (int r = 0; r < 32; r++) begin cnt_m[r] = 0; late_m[r] = 0; end
      if (reset) err_m = 1'b0;
    end else begin
      for (int r = 1; r < 32; r++) begin
        bit ic, dc;
        ic = ds_issue && ds_issue_we && int'(ds_issue_dest) == r;
        dc = ws_retire && int'(ws_retire_dest) == r;
        if (late_m[r] > cnt_m[r]) err_m = 1'b1;
        cnt_m[r]  = nxt(cnt_m[r], ic, dc);
        late_m[r] = nxt(late_m[r], ic && ds_issue_late, dc && ws_retire_late);
      end
    end
  endtask

  task automatic test_reset();
    vec_t v;
    logic [5:0] got;
    exp_t e;
    drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 3, 2));
    repeat (2) @(posedge clk);
    update_model();
    #1;
    drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 3, 2));
    exp_q.push_back('{"reset_query", predict()});
    @(negedge clk);
    e = exp_q.pop_front();
    got = {rd_busy, rd_late, dest_full, sb_err};
    n_vec++;
    if (got !== e.val || got !== 6'b000000) begin
      n_miss++;
      $display("FAIL %s got=%b exp=%b", e.tag, got, 6'b000000);
    end else $display("ok   %s out=%b", e.tag, got);
    @(posedge clk); update_model(); #1;
  endtask

  task automatic test_issue_retire();
    vec_t v[$];
    logic [5:0] got;
    exp_t e;
    v.push_back(mk(1, 1, 5, 0, 0, 0, 0, 0, 0, 6, 5));
    v.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 6, 5));
    v.push_back(mk(0, 0, 0, 0, 1, 5, 0, 0, 0, 6, 5));
    v.push_back(mk(1, 0, 5, 0, 0, 0, 0, 0, 0, 6, 5));
    v.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 6, 5));
    foreach (v[k]) begin
      drive(v[k]);
      exp_q.push_back('{$sformatf("issue_retire[%0d]", k), predict()});
      @(negedge clk);
      e = exp_q.pop_front();
      got = {rd_busy, rd_late, dest_full, sb_err};
      n_vec++;
      if (got !== e.val) begin
        n_miss++;
        $display("FAIL %s got=%b exp=%b", e.tag, got, e.val);
      end else $display("ok   %s out=%b", e.tag, got);
      @(posedge clk); update_model(); #1;
    end
  endtask

  task automatic test_late();
    vec_t v[$];
    logic [5:0] got;
    exp_t e;
    v.push_back(mk(1, 1, 7, 1, 0, 0, 0, 0, 0, 7, 1));
    v.push_back(mk(1, 1, 7, 0, 0, 0, 0, 0, 0, 7, 1));
    v.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 7, 1));
    v.push_back(mk(0, 0, 0, 0, 1, 7, 1, 0, 0, 7, 1));
    v.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 7));
    v.push_back(mk(0, 0, 0, 0, 1, 7, 0, 0, 0, 1, 7));
    v.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 7, 7));
    foreach (v[k]) begin
      drive(v[k]);
      exp_q.push_back('{$sformatf("late[%0d]", k), predict()});
      @(negedge clk);
      e = exp_q.pop_front();
      got = {rd_busy, rd_late, dest_full, sb_err};
      n_vec++;
      if (got !== e.val) begin
        n_miss++;
        $display("FAIL %s got=%b exp=%b", e.tag, got, e.val);
      end else $display("ok   %s out=%b", e.tag, got);
      @(posedge clk); update_model(); #1;
    end
  endtask

  task automatic test_saturate();
    vec_t v[$];
    logic [5:0] got;
    exp_t e;
    for (int n = 0; n < 7; n++) v.push_back(mk(1, 1, 9, 0, 0, 0, 0, 0, 0, 0, 9));
    v.push_back(mk(0, 0, 9, 0, 0, 0, 0, 0, 0, 0, 9));
    v.push_back(mk(1, 1, 9, 0, 0, 0, 0, 0, 0, 0, 9));
    v.push_back(mk(0, 0, 9, 0, 0, 0, 0, 0, 0, 0, 9));
    v.push_back(mk(1, 1, 9, 0, 1, 9, 0, 0, 0, 9, 9));
    v.push_back(mk(0, 0, 9, 0, 0, 0, 0, 0, 0, 9, 9));
    foreach (v[k]) begin
      drive(v[k]);
      exp_q.push_back('{$sformatf("saturate[%0d]", k), predict()});
      @(negedge clk);
      e = exp_q.pop_front();
      got = {rd_busy, rd_late, dest_full, sb_err};
      n_vec++;
      if (got !== e.val) begin
        n_miss++;
        $display("FAIL %s got=%b exp=%b", e.tag, got, e.val);
      end else $display("ok   %s out=%b", e.tag, got);
      @(posedge clk); update_model(); #1;
    end
  endtask

  task automatic test_underflow_r0();
    vec_t v[$];
    logic [5:0] got;
    exp_t e;
    v.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 9, 4));
    v.push_back(mk(0, 0, 9, 0, 0, 0, 0, 0, 0, 9, 4));
    v.push_back(mk(0, 0, 0, 0, 1, 4, 0, 0, 0, 9, 4));
    v.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 9, 4));
    v.push_back(mk(1, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0));
    v.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    foreach (v[k]) begin
      drive(v[k]);
      exp_q.push_back('{$sformatf("underflow_r0[%0d]", k), predict()});
      @(negedge clk);
      e = exp_q.pop_front();
      got = {rd_busy, rd_late, dest_full, sb_err};
      n_vec++;
      if (got !== e.val) begin
        n_miss++;
        $display("FAIL %s got=%b exp=%b", e.tag, got, e.val);
      end else $display("ok   %s out=%b", e.tag, got);
      @(posedge clk); update_model(); #1;
    end
  endtask

  task automatic test_flush();
    vec_t v[$];
    logic [5:0] got;
    exp_t e;
    v.push_back(mk(1, 1, 2, 0, 0, 0, 0, 0, 0, 31, 2));
    v.push_back(mk(1, 1, 3, 1, 0, 0, 0, 0, 0, 31, 2));
    v.push_back(mk(1, 1, 31, 0, 0, 0, 0, 0, 0, 31, 2));
    v.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 31, 2));
    v.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 3, 6));
    v.push_back(mk(1, 1, 6, 0, 1, 3, 1, 1, 0, 6, 2));
    v.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 6, 2));
    v.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 31, 3));
    foreach (v[k]) begin
      drive(v[k]);
      exp_q.push_back('{$sformatf("flush[%0d]", k), predict()});
      @(negedge clk);
      e = exp_q.pop_front();
      got = {rd_busy, rd_late, dest_full, sb_err};
      n_vec++;
      if (got !== e.val) begin
        n_miss++;
        $display("FAIL %s got=%b exp=%b", e.tag, got, e.val);
      end else $display("ok   %s out=%b", e.tag, got);
      @(posedge clk); update_model(); #1;
    end
  endtask

  task automatic test_mid_reset();
    vec_t v[$];
    logic [5:0] got;
    exp_t e;
    v.push_back(mk(1, 1, 10, 1, 0, 0, 0, 0, 0, 10, 11));
    v.push_back(mk(1, 1, 11, 0, 0, 0, 0, 0, 0, 10, 11));
    v.push_back(mk(1, 1, 12, 0, 0, 0, 0, 0, 1, 10, 11));
    v.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 10, 12));
    foreach (v[k]) begin
      drive(v[k]);
      exp_q.push_back('{$sformatf("mid_reset[%0d]", k), predict()});
      @(negedge clk);
      e = exp_q.pop_front();
      got = {rd_busy, rd_late, dest_full, sb_err};
      n_vec++;
      if (got !== e.val) begin
        n_miss++;
        $display("FAIL %s got=%b exp=%b", e.tag, got, e.val);
      end else $display("ok   %s out=%b", e.tag, got);
      @(posedge clk); update_model(); #1;
    end
  endtask

  initial begin
    for (int r = 0; r < 32; r++) begin cnt_m[r] = 0; late_m[r] = 0; end
    err_m = 1'b0;
    test_reset();
    test_issue_retire();
    test_late();
    test_saturate();
    test_underflow_r0();
    test_flush();
    test_mid_reset();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
